// File: rtl/mem_copy_master_if.sv
// ---------------------------------------------------------------------------
// mem_copy_master_if
// Get/Put memory port between a requester (master) and a memory responder
// (slave).
//   obtain_rq_get      [64:0]  request payload: [64:33] address,
//                              [32] iswrite, [31:0] write data
//   RDY_obtain_rq_get          request valid (requester -> responder)
//   EN_obtain_rq_get           responder takes the request
//   send_rs_put        [31:0]  response data (responder -> requester)
//   EN_send_rs_put             responder delivers the response
//   RDY_send_rs_put            requester is waiting for a response
// ---------------------------------------------------------------------------
interface mem_copy_master_if;
  logic [64:0] obtain_rq_get;
  logic        RDY_obtain_rq_get;
  logic        EN_obtain_rq_get;
  logic [31:0] send_rs_put;
  logic        EN_send_rs_put;
  logic        RDY_send_rs_put;

  modport master (
    output obtain_rq_get, RDY_obtain_rq_get, RDY_send_rs_put,
    input  EN_obtain_rq_get, send_rs_put, EN_send_rs_put
  );

  modport slave (
    input  obtain_rq_get, RDY_obtain_rq_get, RDY_send_rs_put,
    output EN_obtain_rq_get, send_rs_put, EN_send_rs_put
  );
endinterface

// File: rtl/mem_copy_master.sv
// ---------------------------------------------------------------------------
// mem_copy_master
// Copies len 32-bit words from src_addr to dst_addr over the Get/Put memory
// port, one request outstanding at a time: read a word, write it, advance
// both addresses by 4 (modulo 2^32), repeat.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 command strobe, sampled only while idle
//   src_addr, dst_addr    byte addresses of the first source/destination word
//   len [LENW-1:0]        number of words; 0 completes without any request
//   busy                  high while the copy is in progress
//   done                  one-cycle completion pulse
//   checksum [31:0]       sum of all read data of the last copy
//                         (only when MEM_COPY_CHECKSUM_EN is defined)
//   bus                   memory port, requester side
//
// Optional feature macro: MEM_COPY_CHECKSUM_EN
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_copy_master #(
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     src_addr,
  input  logic [31:0]     dst_addr,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [31:0]     checksum,
`endif
  mem_copy_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t          state;
  logic [31:0]     src_q;
  logic [31:0]     dst_q;
  logic [LENW-1:0] remaining;

  // Address of the next word; wraps naturally at 2^32, low bits untouched.
  logic [31:0] src_next;
  logic [31:0] dst_next;
  assign src_next = src_q + 32'd4;
  assign dst_next = dst_q + 32'd4;

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      bus.obtain_rq_get     <= '0;
      bus.RDY_obtain_rq_get <= 1'b0;
      bus.RDY_send_rs_put   <= 1'b0;
      src_q                 <= '0;
      dst_q                 <= '0;
      remaining             <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum              <= '0;
`endif
    end else begin
      // done is a pulse: only the transitions into DONE raise it.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
`ifdef MEM_COPY_CHECKSUM_EN
            checksum <= '0;
`endif
            if (len != '0) begin
              src_q                 <= src_addr;
              dst_q                 <= dst_addr;
              remaining             <= len;
              bus.obtain_rq_get     <= {src_addr, 1'b0, 32'h0};
              bus.RDY_obtain_rq_get <= 1'b1;
              busy                  <= 1'b1;
              state                 <= RD_REQ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        // RDY_obtain_rq_get is high throughout RD_REQ/WR_REQ, so EN alone
        // marks acceptance here.
        RD_REQ: begin
          if (bus.EN_obtain_rq_get) begin
            bus.RDY_obtain_rq_get <= 1'b0;
            bus.obtain_rq_get     <= '0;
            bus.RDY_send_rs_put   <= 1'b1;
            state                 <= RD_WAIT;
          end
        end

        // The write payload register doubles as the holding register for
        // the read data.
        RD_WAIT: begin
          if (bus.EN_send_rs_put) begin
            bus.RDY_send_rs_put   <= 1'b0;
            bus.obtain_rq_get     <= {dst_q, 1'b1, bus.send_rs_put};
            bus.RDY_obtain_rq_get <= 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum              <= checksum + bus.send_rs_put;
`endif
            state                 <= WR_REQ;
          end
        end

        WR_REQ: begin
          if (bus.EN_obtain_rq_get) begin
            bus.RDY_obtain_rq_get <= 1'b0;
            bus.obtain_rq_get     <= '0;
            bus.RDY_send_rs_put   <= 1'b1;
            state                 <= WR_WAIT;
          end
        end

        // Write response data carries nothing useful and is dropped.
        WR_WAIT: begin
          if (bus.EN_send_rs_put) begin
            bus.RDY_send_rs_put <= 1'b0;
            src_q               <= src_next;
            dst_q               <= dst_next;
            remaining           <= remaining - LENW'(1);
            if (remaining > LENW'(1)) begin
              bus.obtain_rq_get     <= {src_next, 1'b0, 32'h0};
              bus.RDY_obtain_rq_get <= 1'b1;
              state                 <= RD_REQ;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
